// File: rtl/io_responder.sv
// Memory-mapped I/O target: CPU writes feed a TX stream FIFO, an RX stream FIFO
// feeds CPU reads, and a status port exposes FIFO flags plus sticky error bits.

module io_responder_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [7:0]             wdata_i,
    input  logic                   pop_i,
    output logic [7:0]             head_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_i && !pop_i)      count_d = count_q + 1'b1;
        else if (pop_i && !push_i) count_d = count_q - 1'b1;
    end

    // NOTE: storage is deliberately not reset; consumers qualify the head with the count.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

module io_responder #(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] OUT_PORT  = 8'h00,
    parameter logic [7:0] IN_PORT   = 8'h01,
    parameter logic [7:0] STAT_PORT = 8'h02,
    parameter logic [7:0] EMPTY_VAL = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_sel,
    input  logic [7:0] io_addr,
    input  logic       io_wr,
    input  logic       io_rd,
    input  logic       io_stb,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       bad_access
);
    localparam int            CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic          acc, rd_only, wr_only, is_out, is_in, is_stat, legal;
    logic          tx_wr, stat_wr, in_rd;
    logic          tx_pop, tx_push, rx_pop, rx_push;
    logic          tx_full, tx_empty, rx_nonempty;
    logic [7:0]    tx_head, rx_head, status;
    logic [CW-1:0] tx_count, rx_count;
    logic          tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d, bad_q, bad_d;

    assign acc     = io_sel & io_stb;
    assign rd_only = io_rd & ~io_wr;
    assign wr_only = io_wr & ~io_rd;
    assign is_out  = (io_addr == OUT_PORT);
    assign is_in   = (io_addr == IN_PORT);
    assign is_stat = (io_addr == STAT_PORT);
    assign legal   = (wr_only & (is_out | is_stat)) | (rd_only & (is_in | is_stat));

    assign tx_wr   = acc & wr_only & is_out;
    assign stat_wr = acc & wr_only & is_stat;
    assign in_rd   = acc & rd_only & is_in;

    assign tx_full     = (tx_count == FULL_COUNT);
    assign tx_empty    = (tx_count == '0);
    assign rx_nonempty = (rx_count != '0);

    // A full TX FIFO still accepts a write when the consumer drains a slot this cycle.
    assign tx_pop  = tx_valid & tx_ready;
    assign tx_push = tx_wr & (~tx_full | tx_pop);
    assign rx_push = rx_valid & rx_ready;
    assign rx_pop  = in_rd & rx_nonempty;

    io_responder_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_push),
        .wdata_i (bus_in),
        .pop_i   (tx_pop),
        .head_o  (tx_head),
        .count_o (tx_count)
    );

    io_responder_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push),
        .wdata_i (rx_data),
        .pop_i   (rx_pop),
        .head_o  (rx_head),
        .count_o (rx_count)
    );

    // Sticky set takes priority over a write-1-to-clear in the same cycle.
    always_comb begin
        tx_ovf_d = tx_ovf_q & ~(stat_wr & bus_in[3]);
        rx_unf_d = rx_unf_q & ~(stat_wr & bus_in[4]);
        if (tx_wr && !tx_push)     tx_ovf_d = 1'b1;
        if (in_rd && !rx_nonempty) rx_unf_d = 1'b1;
        bad_d = acc & ~legal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
            bad_q    <= bad_d;
        end
    end

    assign status = {3'b000, rx_unf_q, tx_ovf_q, rx_nonempty, tx_empty, tx_full};
    assign bus_oe = io_sel & rd_only & (is_in | is_stat);

    always_comb begin
        bus_out = 8'h00;
        if (bus_oe) begin
            if (is_in) bus_out = rx_nonempty ? rx_head : EMPTY_VAL;
            else       bus_out = status;
        end
    end

    assign tx_valid   = ~tx_empty;
    assign tx_data    = tx_valid ? tx_head : 8'h00;
    assign rx_ready   = (rx_count != FULL_COUNT);
    assign bad_access = bad_q;
endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: queue-based reference model, directed
// scenarios followed by randomized CPU/stream traffic with occasional resets.

module tb_io_responder;
    localparam int         DEPTH  = 4;
    localparam logic [7:0] OUT_P  = 8'h00;
    localparam logic [7:0] IN_P   = 8'h01;
    localparam logic [7:0] STAT_P = 8'h02;

    logic       clk = 1'b0;
    logic       reset, io_sel, io_wr, io_rd, io_stb, tx_ready, rx_valid;
    logic [7:0] io_addr, bus_in, rx_data;
    logic [7:0] bus_out, tx_data;
    logic       bus_oe, tx_valid, rx_ready, bad_access;

    io_responder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .io_sel     (io_sel),
        .io_addr    (io_addr),
        .io_wr      (io_wr),
        .io_rd      (io_rd),
        .io_stb     (io_stb),
        .bus_in     (bus_in),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .bad_access (bad_access)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO contents as queues plus sticky flags.
    logic [7:0] tx_m[$];
    logic [7:0] rx_m[$];
    bit         ovf_m, unf_m, bad_exp, exp_oe;
    logic [7:0] exp_bus;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] stat_m();
        return {3'b000, unf_m, ovf_m, rx_m.size() != 0, tx_m.size() == 0, tx_m.size() == DEPTH};
    endfunction

    // One clock cycle: predict from the current inputs, wait for the edge, update the model.
    task automatic tick();
        bit rd1, wr1, acc, is_out, is_in, is_st, legal;
        bit tx_push, ovf_set, ovf_clr, unf_set, unf_clr, rx_push, rx_pop, bad_n;
        logic [7:0] wd, rd_in;
        rd1     = io_rd && !io_wr;
        wr1     = io_wr && !io_rd;
        acc     = io_sel && io_stb;
        is_out  = (io_addr == OUT_P);
        is_in   = (io_addr == IN_P);
        is_st   = (io_addr == STAT_P);
        legal   = (wr1 && (is_out || is_st)) || (rd1 && (is_in || is_st));
        exp_oe  = io_sel && rd1 && (is_in || is_st);
        exp_bus = 8'h00;
        if (exp_oe) exp_bus = is_in ? ((rx_m.size() != 0) ? rx_m[0] : 8'hFF) : stat_m();
        tx_push = acc && wr1 && is_out && (tx_m.size() < DEPTH || (tx_ready && tx_m.size() != 0));
        ovf_set = acc && wr1 && is_out && !tx_push;
        ovf_clr = acc && wr1 && is_st && bus_in[3];
        unf_clr = acc && wr1 && is_st && bus_in[4];
        rx_push = rx_valid && (rx_m.size() < DEPTH);
        rx_pop  = acc && rd1 && is_in && (rx_m.size() != 0);
        unf_set = acc && rd1 && is_in && (rx_m.size() == 0);
        bad_n   = acc && !legal;
        wd      = bus_in;
        rd_in   = rx_data;
        @(posedge clk);
        if (reset) begin
            tx_m.delete();
            rx_m.delete();
            ovf_m   = 1'b0;
            unf_m   = 1'b0;
            bad_exp = 1'b0;
        end else begin
            if (tx_push) tx_m.push_back(wd);
            if (rx_pop)  void'(rx_m.pop_front());
            if (rx_push) rx_m.push_back(rd_in);
            ovf_m   = ovf_set || (ovf_m && !ovf_clr);
            unf_m   = unf_set || (unf_m && !unf_clr);
            bad_exp = bad_n;
        end
        #1;
    endtask

    // Monitor: mid-cycle, compare every output against the model; TX pops drain the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            check("tx_valid", tx_valid, tx_m.size() != 0);
            if (tx_valid && tx_m.size() != 0) begin
                check("tx_data", tx_data, tx_m[0]);
                if (tx_ready) void'(tx_m.pop_front());
            end
            check("rx_ready", rx_ready, rx_m.size() < DEPTH);
            check("bus_oe", bus_oe, exp_oe);
            check("bus_out", bus_out, exp_bus);
            check("bad_access", bad_access, bad_exp);
        end
    end

    task automatic bus_idle();
        io_sel = 1'b0; io_stb = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
        io_addr = 8'h00; bus_in = 8'h00;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        io_sel = 1'b1; io_stb = 1'b1; io_wr = 1'b1; io_rd = 1'b0;
        io_addr = a; bus_in = d;
        tick();
        bus_idle();
    endtask

    task automatic cpu_read_expect(input string name, input logic [7:0] a, input logic [7:0] exp);
        io_sel = 1'b1; io_stb = 1'b1; io_rd = 1'b1; io_wr = 1'b0; io_addr = a;
        #1;
        check(name, bus_out, exp);
        tick();
        bus_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] addrs [5];

    initial begin
        addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07};
        reset = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        bus_idle();
        tick(); tick();
        reset = 1'b0;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_bad", bad_access, 1'b0);
        check("rst_bus_oe", bus_oe, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);

        // TX ordering with backpressure.
        cpu_write(OUT_P, 8'h11); cpu_write(OUT_P, 8'h22); cpu_write(OUT_P, 8'h33);
        check("tx_hold_valid", tx_valid, 1'b1);
        check("tx_hold_data", tx_data, 8'h11);
        tick();
        check("tx_held_data", tx_data, 8'h11);
        tx_ready = 1'b1;
        tick(); tick(); tick();
        tx_ready = 1'b0;
        check("tx_drained", tx_valid, 1'b0);

        // Overflow and write-1-to-clear.
        for (int i = 0; i < 5; i++) cpu_write(OUT_P, 8'hA0 + 8'(i));
        cpu_read_expect("stat_ovf", STAT_P, 8'h09);
        cpu_write(STAT_P, 8'h08);
        cpu_read_expect("stat_ovf_clr", STAT_P, 8'h01);

        // Write into a full FIFO while it drains a slot.
        tx_ready = 1'b1;
        cpu_write(OUT_P, 8'h44);
        tick(); tick(); tick(); tick();
        tx_ready = 1'b0;
        check("tx_after_44", tx_valid, 1'b0);
        cpu_read_expect("stat_no_ovf", STAT_P, 8'h02);

        // RX path, empty read and underflow.
        rx_valid = 1'b1; rx_data = 8'hA5; tick();
        rx_data = 8'h5A; tick();
        rx_valid = 1'b0;
        cpu_read_expect("rx_a5", IN_P, 8'hA5);
        cpu_read_expect("rx_5a", IN_P, 8'h5A);
        cpu_read_expect("rx_empty", IN_P, 8'hFF);
        cpu_read_expect("stat_unf", STAT_P, 8'h12);
        cpu_write(STAT_P, 8'h10);
        cpu_read_expect("stat_unf_clr", STAT_P, 8'h02);

        // RX full: rx_ready low, pop does not raise it in the same cycle.
        rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin rx_data = 8'hC0 + 8'(i); tick(); end
        rx_data = 8'hC4;
        check("rx_full_ready", rx_ready, 1'b0);
        cpu_read_expect("rx_c0", IN_P, 8'hC0);
        rx_valid = 1'b0;
        check("rx_ready_back", rx_ready, 1'b1);
        cpu_read_expect("rx_c1", IN_P, 8'hC1);
        cpu_read_expect("rx_c2", IN_P, 8'hC2);
        cpu_read_expect("rx_c3", IN_P, 8'hC3);

        // Illegal accesses.
        cpu_read_expect("unmapped_bus", 8'h07, 8'h00);
        check("bad_unmapped", bad_access, 1'b1);
        tick();
        check("bad_pulse_end", bad_access, 1'b0);
        io_sel = 1'b1; io_stb = 1'b1; io_rd = 1'b1; io_wr = 1'b1; io_addr = IN_P;
        #1;
        check("rdwr_no_oe", bus_oe, 1'b0);
        tick();
        bus_idle();
        check("bad_rdwr", bad_access, 1'b1);
        tick();
        check("bad_rdwr_end", bad_access, 1'b0);
        cpu_read_expect("stat_unchanged", STAT_P, 8'h02);

        // Reset with traffic queued both ways.
        cpu_write(OUT_P, 8'h55); cpu_write(OUT_P, 8'h66);
        rx_valid = 1'b1; rx_data = 8'h77; tick(); rx_data = 8'h88; tick();
        rx_valid = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst_tx_valid", tx_valid, 1'b0);
        cpu_read_expect("mid_rst_stat", STAT_P, 8'h02);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 299) == 0);
            io_sel   = ($urandom_range(0, 3) != 0);
            io_stb   = $urandom_range(0, 1) != 0;
            io_addr  = addrs[$urandom_range(0, 4)];
            case ($urandom_range(0, 9))
                0:       begin io_rd = 1'b1; io_wr = 1'b1; end
                1:       begin io_rd = 1'b0; io_wr = 1'b0; end
                2, 3, 4: begin io_rd = 1'b1; io_wr = 1'b0; end
                default: begin io_rd = 1'b0; io_wr = 1'b1; end
            endcase
            bus_in   = 8'($urandom);
            tx_ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rx_valid = $urandom_range(0, 1) != 0;
            rx_data  = 8'($urandom);
            tick();
        end
        reset = 1'b0;
        bus_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Memory-mapped I/O responder on the CPU's I/O cycles (io_sel high): the target end of the CPU I/O protocol.
- CPU writes to OUT_PORT are queued into a TX FIFO and drained by an external consumer over a valid/ready stream.
- An external producer pushes bytes into an RX FIFO over valid/ready; CPU reads of IN_PORT pop it.
- STAT_PORT exposes FIFO flags and sticky error bits.

Parameters:
DEPTH, 4, entries per FIFO; power of two, >=2
OUT_PORT, 8'h00, I/O address of TX data (write-only)
IN_PORT, 8'h01, I/O address of RX data (read-only)
STAT_PORT, 8'h02, I/O address of status (read; write-1-to-clear stickies)
EMPTY_VAL, 8'hFF, value returned on an IN_PORT read while RX FIFO is empty

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high
io_sel  input  1  CPU is in an I/O cycle (mem_io)
io_addr  input  8  I/O address (addr_bus)
io_wr  input  1  CPU writes data to bus (c_ri)
io_rd  input  1  CPU reads data from bus (c_ro)
io_stb  input  1  one-clk commit strobe of the I/O cycle
bus_in  input  8  data from CPU
bus_out  output  8  data to CPU
bus_oe  output  1  drive enable for bus_out onto shared tri-state bus
tx_data  output  8  TX FIFO head
tx_valid  output  1  TX FIFO non-empty
tx_ready  input  1  consumer accepts tx_data
rx_data  input  8  producer byte
rx_valid  input  1  producer byte valid
rx_ready  output  1  RX FIFO not full
bad_access  output  1  one-clk pulse on illegal committed access

Behaviour:
- Reset (sync, active-high): both FIFOs empty, pointers/counts 0, stickies 0. Outputs after the reset edge: tx_valid=0, rx_ready=1, bad_access=0, bus_oe=0 (io_sel low), tx_data=0.
- Access qualifier: acc = io_sel & io_stb. Exactly one of io_rd/io_wr is legal. Both high or address not in {OUT, IN, STAT}: no state change, no drive, bad_access=1 for the next cycle.
- Read path, combinational, zero latency:
  - bus_oe = io_sel & io_rd & !io_wr & (io_addr==IN_PORT | io_addr==STAT_PORT).
  - IN_PORT: bus_out = RX head, or EMPTY_VAL if RX is empty.
  - STAT_PORT: bus_out = {3'b0, rx_underflow, tx_overflow, rx_nonempty, tx_empty, tx_full}.
  - bus_out = 0 when bus_oe=0.
- IN_PORT read commit (acc & io_rd & addr==IN_PORT):
  - RX non-empty: pop one entry at this edge.
  - RX empty: no pop; set rx_underflow sticky.
- OUT_PORT write commit: push bus_in into TX if there is space; otherwise drop it and set tx_overflow sticky.
  - Space includes a slot freed this same cycle by tx_valid & tx_ready, so a write to a full FIFO is accepted when a pop coincides.
- STAT_PORT write commit: bus_in[3]=1 clears tx_overflow; bus_in[4]=1 clears rx_underflow. Other bits are ignored.
  - A set event and a clear in the same cycle: set wins.
- Writes to IN_PORT and reads of OUT_PORT are illegal and raise bad_access.
- TX stream:
  - tx_valid = count!=0; tx_data = head (registered storage).
  - Pop on tx_valid & tx_ready.
  - tx_data is held stable while tx_valid & !tx_ready.
- RX stream:
  - rx_ready = RX count != DEPTH (from registered count only).
  - Push on rx_valid & rx_ready.
  - A simultaneous CPU pop on a full RX FIFO does not raise rx_ready in that cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Counts are $clog2(DEPTH)+1 bits. A simultaneous push and pop leaves count unchanged and advances both pointers.
- Data order is strictly FIFO on both paths.
- Reset mid-traffic: all queued data is discarded; the next accepted byte on either path is delivered first after reset.
- A committed access needs io_stb. An io_sel/io_rd level without the strobe only drives the bus and never pops.

Test Plan:
- Reset, then CPU writes 8'h11, 8'h22, 8'h33 to OUT_PORT with tx_ready=0 -> tx_valid=1, tx_data=8'h11 held. Raise tx_ready -> 11,22,33 in order, then tx_valid=0.
- DEPTH=4, tx_ready=0, write 5 bytes -> STAT read = 8'h09 (tx_full, tx_overflow); 5th byte absent from stream. Write 8'h08 to STAT -> STAT = 8'h01.
- Write 8'h44 to full TX in the same cycle as tx_valid&tx_ready -> accepted; stream ends ...,8'h44; tx_overflow stays 0.
- Producer pushes 8'hA5, 8'h5A; CPU reads IN_PORT twice -> A5 then 5A, bus_oe=1. Third read -> 8'hFF, STAT = 8'h12.
- Fill RX to 4 -> rx_ready=0 and 5th rx_valid byte not taken. CPU pop -> rx_ready=1 next cycle.
- Read of io_addr=8'h07 and a strobe with io_rd=io_wr=1 -> bus_oe=0 for the unmapped address, bad_access one-cycle pulse each time, FIFOs unchanged.
- Assert reset with 2 bytes queued each way -> tx_valid=0, STAT=8'h02.
